// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control unit: state encoding, opcode
// classes, datapath select codes and the opcode classifier.
package controle_pkg;

  typedef enum logic [2:0] {
    BUSCA,
    DECODIFICA,
    EXECUTA,
    MUL_ESPERA,
    ESCRITA
  } estado_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_IMM,
    CL_JMP,
    CL_BR,
    CL_MUL,
    CL_ILEGAL
  } classe_t;

  localparam logic [1:0] B_REG  = 2'b00;
  localparam logic [1:0] B_UM   = 2'b01;
  localparam logic [1:0] B_IMM  = 2'b10;
  localparam logic [1:0] B_DESL = 2'b11;

  localparam logic [1:0] CP_ULA      = 2'b00;
  localparam logic [1:0] CP_ULASAIDA = 2'b01;
  localparam logic [1:0] CP_SALTO    = 2'b10;

  function automatic classe_t classe(input logic [31:0] op);
    classe_t c;
    if (op >= 32'd16) begin
      c = CL_ILEGAL;
    end else begin
      case (op[3:0])
        4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd13, 4'd14: c = CL_R;
        4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:        c = CL_IMM;
        4'd11:                                      c = CL_JMP;
        4'd12:                                      c = CL_BR;
        default:                                    c = CL_MUL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/contador_mul.sv
// Multiplier wait counter: loaded with MUL_CICLOS-2 when the multiply starts,
// counts down while waiting and flags completion at zero.
module contador_mul #(
  parameter int unsigned MUL_CICLOS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_fim
);

  localparam int unsigned W = (MUL_CICLOS > 2) ? $clog2(MUL_CICLOS - 1) : 1;
  localparam logic [W-1:0] CARGA = W'((MUL_CICLOS > 1) ? MUL_CICLOS - 2 : 0);

  logic [W-1:0] r_mc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc <= '0;
    end else if (i_load) begin
      r_mc <= CARGA;
    end else if (i_dec && (r_mc != '0)) begin
      r_mc <= r_mc - 1'b1;
    end
  end

  assign o_fim = (r_mc == '0);

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: fetch/decode/execute/write-back sequencing with
// memory-ready stall, multi-cycle multiply hold, illegal-opcode flag and retire count.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int unsigned OPW        = 4,
  parameter int unsigned MUL_CICLOS = 4,
  parameter int unsigned CONT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_pronto,
  output logic              EscCondCP,
  output logic              EscCP,
  output logic              EscIR,
  output logic              EscReg,
  output logic              ULA_A,
  output logic [1:0]        ULA_B,
  output logic [OPW-1:0]    ULA_OP,
  output logic [1:0]        FonteCP,
  output logic              flagimm,
  output logic              mul,
  output logic              instr_fim,
  output logic              erro,
  output logic [CONT_W-1:0] n_instr
);

  estado_t           r_estado;
  logic [OPW-1:0]    r_opcode;
  logic [CONT_W-1:0] r_n;
  classe_t           w_classe;
  logic              w_mc_carga;
  logic              w_mc_fim;

  assign w_classe   = classe(32'(r_opcode));
  assign w_mc_carga = (r_estado == EXECUTA) && (w_classe == CL_MUL);

  contador_mul #(.MUL_CICLOS(MUL_CICLOS)) u_contador_mul (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_mc_carga),
    .i_dec  (r_estado == MUL_ESPERA),
    .o_fim  (w_mc_fim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= BUSCA;
      r_opcode <= '0;
      r_n      <= '0;
    end else begin
      if (instr_fim) r_n <= r_n + 1'b1;
      unique case (r_estado)
        BUSCA:      if (mem_pronto) r_estado <= DECODIFICA;
        DECODIFICA: begin
          r_opcode <= opcode;
          r_estado <= EXECUTA;
        end
        EXECUTA: begin
          case (w_classe)
            CL_R, CL_IMM: r_estado <= ESCRITA;
            CL_MUL:       r_estado <= (MUL_CICLOS > 1) ? MUL_ESPERA : ESCRITA;
            default:      r_estado <= BUSCA;
          endcase
        end
        MUL_ESPERA: if (w_mc_fim) r_estado <= ESCRITA;
        ESCRITA:    r_estado <= BUSCA;
        default:    r_estado <= BUSCA;
      endcase
    end
  end

  // EXECUTA, MUL_ESPERA and ESCRITA share the class selects; only the
  // write-back enables and the mul hold differ between them.
  always_comb begin
    EscCondCP = 1'b0;
    EscCP     = 1'b0;
    EscIR     = 1'b0;
    EscReg    = 1'b0;
    ULA_A     = 1'b0;
    ULA_B     = B_REG;
    ULA_OP    = '0;
    FonteCP   = CP_ULA;
    flagimm   = 1'b0;
    mul       = 1'b0;
    instr_fim = 1'b0;
    erro      = 1'b0;
    case (r_estado)
      BUSCA: begin
        ULA_B = B_UM;
        EscIR = mem_pronto;
        EscCP = mem_pronto;
      end
      DECODIFICA: ULA_B = B_DESL;
      EXECUTA, MUL_ESPERA, ESCRITA: begin
        ULA_OP = r_opcode;
        case (w_classe)
          CL_R: ULA_A = 1'b1;
          CL_IMM: begin
            ULA_A   = 1'b1;
            ULA_B   = B_IMM;
            flagimm = 1'b1;
          end
          CL_MUL: begin
            ULA_A = 1'b1;
            mul   = (r_estado != ESCRITA);
          end
          CL_JMP: begin
            ULA_B     = B_IMM;
            FonteCP   = CP_SALTO;
            EscCP     = 1'b1;
            instr_fim = 1'b1;
          end
          CL_BR: begin
            ULA_A     = 1'b1;
            FonteCP   = CP_ULASAIDA;
            EscCondCP = 1'b1;
            instr_fim = 1'b1;
          end
          default: erro = 1'b1;
        endcase
        if (r_estado == ESCRITA) begin
          EscReg    = 1'b1;
          instr_fim = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign n_instr = r_n;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench: a per-instruction model expands each instruction into
// its expected per-cycle output sequence; two parameterisations run side by side.
module tb_controle_multiciclo;

  localparam int C_R = 0, C_IMM = 1, C_JMP = 2, C_BR = 3, C_MUL = 4, C_ILL = 5;

  typedef struct packed {
    logic       esccond, esccp, escir, escreg, ula_a;
    logic [1:0] ula_b;
    logic [7:0] ula_op;
    logic [1:0] fontecp;
    logic       flagimm, mul, fim, erro;
    logic [15:0] n;
  } vec_t;

  typedef struct packed {
    logic       chk, rst, pronto;
    logic [7:0] op;
    vec_t       e;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: OPW=4, MUL_CICLOS=4, CONT_W=16
  logic rstA = 1'b1, prA = 1'b0;
  logic [3:0] opA = '0;
  logic ecA, ecpA, eirA, erA, uaA, mulA, fiA, flA, erroA;
  logic [1:0] ubA, fcA;
  logic [3:0] uopA;
  logic [15:0] nA;

  // DUT B: OPW=5, MUL_CICLOS=1, CONT_W=2
  logic rstB = 1'b1, prB = 1'b0;
  logic [4:0] opB = '0;
  logic ecB, ecpB, eirB, erB, uaB, mulB, fiB, flB, erroB;
  logic [1:0] ubB, fcB;
  logic [4:0] uopB;
  logic [1:0] nB;

  controle_multiciclo #(.OPW(4), .MUL_CICLOS(4), .CONT_W(16)) dut_a (
    .clk(clk), .rst(rstA), .opcode(opA), .mem_pronto(prA),
    .EscCondCP(ecA), .EscCP(ecpA), .EscIR(eirA), .EscReg(erA),
    .ULA_A(uaA), .ULA_B(ubA), .ULA_OP(uopA), .FonteCP(fcA),
    .flagimm(flA), .mul(mulA), .instr_fim(fiA), .erro(erroA), .n_instr(nA)
  );

  controle_multiciclo #(.OPW(5), .MUL_CICLOS(1), .CONT_W(2)) dut_b (
    .clk(clk), .rst(rstB), .opcode(opB), .mem_pronto(prB),
    .EscCondCP(ecB), .EscCP(ecpB), .EscIR(eirB), .EscReg(erB),
    .ULA_A(uaB), .ULA_B(ubB), .ULA_OP(uopB), .FonteCP(fcB),
    .flagimm(flB), .mul(mulB), .instr_fim(fiB), .erro(erroB), .n_instr(nB)
  );

  int n_checks = 0;
  int n_fail   = 0;

  entry_t q0[$];
  entry_t q1[$];
  int unsigned nm[2];
  int unsigned contw[2] = '{16, 2};
  int unsigned mulc[2]  = '{4, 1};
  int unsigned omask[2] = '{15, 31};

  vec_t expA, expB;
  logic chkA = 1'b0, chkB = 1'b0;
  logic knownA = 1'b0, knownB = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int cls(input int op);
    if (op >= 16) return C_ILL;
    if (op inside {0, 1, 3, 4, 5, 13, 14}) return C_R;
    if (op inside {2, 6, 7, 8, 9, 10}) return C_IMM;
    if (op == 11) return C_JMP;
    if (op == 12) return C_BR;
    return C_MUL;
  endfunction

  function automatic vec_t idle(input int w);
    vec_t e;
    e = '0;
    e.ula_b = 2'b01;
    e.n = 16'(nm[w]);
    return e;
  endfunction

  task automatic pushe(input int w, input logic rst, input logic pronto, input int op, input vec_t e,
                       input logic chk);
    entry_t x;
    x.chk = chk; x.rst = rst; x.pronto = pronto; x.op = 8'(op); x.e = e;
    if (w == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic bump(input int w);
    nm[w] = (nm[w] + 1) % (32'd1 << contw[w]);
  endtask

  task automatic plan_reset(input int w);
    pushe(w, 1'b1, 1'b0, 0, '0, 1'b0);
    nm[w] = 0;
  endtask

  // Expands one instruction into expected cycles; abort_k>0 asserts rst in that MUL wait cycle.
  task automatic plan(input int w, input int op, input int waits, input int abort_k);
    vec_t e, ex;
    int c, g;
    c = cls(op);
    g = (op + 7) & int'(omask[w]);
    repeat (waits) pushe(w, 1'b0, 1'b0, g, idle(w), 1'b1);
    e = idle(w); e.escir = 1'b1; e.esccp = 1'b1;
    pushe(w, 1'b0, 1'b1, g, e, 1'b1);
    e = '0; e.ula_b = 2'b11; e.n = 16'(nm[w]);
    pushe(w, 1'b0, 1'b1, op, e, 1'b1);
    ex = '0; ex.n = 16'(nm[w]); ex.ula_op = 8'(op);
    case (c)
      C_R:   ex.ula_a = 1'b1;
      C_IMM: begin ex.ula_a = 1'b1; ex.ula_b = 2'b10; ex.flagimm = 1'b1; end
      C_MUL: begin ex.ula_a = 1'b1; ex.mul = 1'b1; end
      C_JMP: begin ex.ula_b = 2'b10; ex.fontecp = 2'b10; ex.esccp = 1'b1; ex.fim = 1'b1; end
      C_BR:  begin ex.ula_a = 1'b1; ex.fontecp = 2'b01; ex.esccond = 1'b1; ex.fim = 1'b1; end
      default: ex.erro = 1'b1;
    endcase
    pushe(w, 1'b0, 1'b1, g, ex, 1'b1);
    if (c == C_JMP || c == C_BR) begin bump(w); return; end
    if (c == C_ILL) return;
    if (c == C_MUL) begin
      for (int k = 1; k < int'(mulc[w]); k++) begin
        if (k == abort_k) begin
          pushe(w, 1'b1, 1'b0, g, ex, 1'b1);
          nm[w] = 0;
          return;
        end
        pushe(w, 1'b0, 1'b1, g, ex, 1'b1);
      end
    end
    e = ex; e.mul = 1'b0; e.escreg = 1'b1; e.fim = 1'b1;
    pushe(w, 1'b0, 1'b1, g, e, 1'b1);
    bump(w);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) check("drain_timeout", 64'(t), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    entry_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) begin
        x = q0.pop_front();
        rstA = x.rst; prA = x.pronto; opA = x.op[3:0]; expA = x.e; chkA = x.chk;
        if (x.rst) knownA = 1'b1;
      end else begin
        rstA = 1'b0; prA = 1'b0; expA = idle(0); chkA = knownA;
      end
      if (q1.size() != 0) begin
        x = q1.pop_front();
        rstB = x.rst; prB = x.pronto; opB = x.op[4:0]; expB = x.e; chkB = x.chk;
        if (x.rst) knownB = 1'b1;
      end else begin
        rstB = 1'b0; prB = 1'b0; expB = idle(1); chkB = knownB;
      end
    end
  end

  always @(negedge clk) begin
    vec_t a;
    if (chkA) begin
      a = {ecA, ecpA, eirA, erA, uaA, ubA, 8'(uopA), fcA, flA, mulA, fiA, erroA, nA};
      check("A_cycle", 64'(a), 64'(expA));
    end
    if (chkB) begin
      a = {ecB, ecpB, eirB, erB, uaB, ubB, 8'(uopB), fcB, flB, mulB, fiB, erroB, 16'(nB)};
      check("B_cycle", 64'(a), 64'(expB));
    end
  end

  initial begin
    plan_reset(0);
    plan_reset(1);
    wait_drain();
    repeat (2) @(negedge clk);
    check("A_reset_ulab", 64'(ubA), 64'(2'b01));
    check("A_reset_n", 64'(nA), 64'(0));

    plan(0, 0, 0, 0);
    check("A_R_len", 64'(q0.size()), 64'(4));
    wait_drain();
    check("A_R_n", 64'(nA), 64'(1));

    plan(0, 6, 3, 0);
    check("A_IMM_len", 64'(q0.size()), 64'(7));
    wait_drain();
    check("A_IMM_n", 64'(nA), 64'(2));

    plan(0, 15, 0, 0);
    check("A_MUL_len", 64'(q0.size()), 64'(7));
    wait_drain();
    check("A_MUL_n", 64'(nA), 64'(3));

    plan_reset(0);
    plan(0, 11, 0, 0);
    check("A_JMP_len", 64'(q0.size()), 64'(4));
    plan(0, 12, 0, 0);
    wait_drain();
    check("A_JMPBR_n", 64'(nA), 64'(2));

    plan(0, 13, 1, 0);
    plan(0, 9, 0, 0);
    wait_drain();
    check("A_more_n", 64'(nA), 64'(4));

    plan(0, 15, 2, 2);
    wait_drain();
    check("A_abort_n", 64'(nA), 64'(0));
    check("A_abort_mul", 64'(mulA), 64'(0));

    plan(1, 15, 0, 0);
    check("B_MUL1_len", 64'(q1.size()), 64'(4));
    wait_drain();
    check("B_n1", 64'(nB), 64'(1));
    plan(1, 20, 0, 0);
    wait_drain();
    check("B_ilegal_n", 64'(nB), 64'(1));
    plan(1, 3, 0, 0);
    wait_drain();
    check("B_n2", 64'(nB), 64'(2));
    plan(1, 10, 1, 0);
    wait_drain();
    check("B_n3", 64'(nB), 64'(3));
    plan(1, 11, 0, 0);
    wait_drain();
    check("B_n0_wrap", 64'(nB), 64'(0));
    plan(1, 12, 0, 0);
    wait_drain();
    check("B_n1_wrap", 64'(nB), 64'(1));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
